shared_reg_arb: RTL and testbench

SHARED_REG_ARB -- requirements
Module: shared_reg_arb

---
 rtl/shared_reg_arb_pkg.sv | 13 +
 rtl/shared_reg_arb_rr_pick.sv | 31 +++
 rtl/shared_reg_arb.sv | 169 ++++++++++++++++
 tb/tb_shared_reg_arb.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared types and constants for the shared_reg_arb block.
package shared_reg_arb_pkg;

  // Arbiter FSM: IDLE drives no grant, GRANT drives a one-hot grant.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_N_REQ = 4;
  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shared_reg_arb_rr_pick.sv
// Combinational round-robin picker. The search starts at the index just
// above i_ptr, wraps from N_REQ-1 to 0, and visits i_ptr itself last.
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter  int N_REQ = DEFAULT_N_REQ,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_win,
  output logic             o_valid
);

  logic [PTR_W-1:0] idx;

  // First requester found after i_ptr wins; later hits are ignored.
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = PTR_W'((int'(i_ptr) + off) % N_REQ);
      if (!o_valid && i_req[idx]) begin
        o_win[idx] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arb.sv
// Round-robin arbitrated shared register.
// Optional feature: define SHARED_REG_ARB_LOCK_EN to let a grantee hold its
// grant across captures while i_lock[k] stays high. In the default build
// i_lock is accepted but has no effect.
//
// Handshake: o_gnt[k] is registered. A capture happens at the edge that
// closes a cycle where o_gnt[k]=1 and i_req[k]=1; o_q then shows i_data[k]
// and o_valid pulses for exactly that following cycle. A grantee that has
// dropped i_req[k] by then loses the grant with no capture.
module shared_reg_arb
  import shared_reg_arb_pkg::*;
#(
  parameter  int N_REQ = DEFAULT_N_REQ,
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ-1:0]       i_lock,
  input  logic [N_REQ*WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [WIDTH-1:0]       o_q,
  output logic                   o_valid,
  output state_t                 o_dbg_state,
  output logic [PTR_W-1:0]       o_dbg_ptr
);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               valid_q, valid_d;

  logic [PTR_W-1:0]   gnt_idx;
  logic [WIDTH-1:0]   sel_data;
  logic               capture;
  logic               lock_hold;
  logic [PTR_W-1:0]   pick_ptr;
  logic [N_REQ-1:0]   pick_win;
  logic               pick_valid;

`ifdef SHARED_REG_ARB_LOCK_EN
  // Lock only matters at a capture, which already implies i_req[k]=1.
  assign lock_hold = |(gnt_q & i_lock);
`else
  logic unused_lock;
  assign unused_lock = ^i_lock;
  assign lock_hold   = 1'b0;
`endif

  // Decode the one-hot grant into an index and the grantee's data lane.
  always_comb begin
    gnt_idx  = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q[k]) begin
        gnt_idx  = PTR_W'(k);
        sel_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // A capture moves the pointer to the grantee, so re-arbitration searches
  // from there and the captured requester ends up lowest priority.
  always_comb begin
    capture  = (state_q == ST_GRANT) && |(gnt_q & i_req);
    pick_ptr = capture ? gnt_idx : ptr_q;
  end

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req   (i_req),
    .i_ptr   (pick_ptr),
    .o_win   (pick_win),
    .o_valid (pick_valid)
  );

  // Next-state, grant, pointer and data computation.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    q_d     = q_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          gnt_d   = pick_win;
        end
      end
      ST_GRANT: begin
        if (capture) begin
          q_d     = sel_data;
          valid_d = 1'b1;
          ptr_d   = gnt_idx;
          // The grantee still requests, so pick_valid is always set here.
          if (!lock_hold) begin
            gnt_d = pick_win;
          end
        end else if (pick_valid) begin
          gnt_d = pick_win;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // FSM state and grant register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
    end else if (i_cg) begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end else begin
      state_q <= state_q;
      gnt_q   <= gnt_q;
    end
  end

  // Round-robin pointer; reset value gives index 0 first priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= PTR_W'(N_REQ - 1);
    end else if (i_cg) begin
      ptr_q <= ptr_d;
    end else begin
      ptr_q <= ptr_q;
    end
  end

  // Shared register; changes only on a capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q_q <= '0;
    end else if (i_cg) begin
      q_q <= q_d;
    end else begin
      q_q <= q_q;
    end
  end

  // Update strobe; forced low while the clock gate is closed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
    end else if (i_cg) begin
      valid_q <= valid_d;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_q         = q_q;
  assign o_valid     = valid_q;
  assign o_dbg_state = state_q;
  assign o_dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_shared_reg_arb.sv
// Directed bench for shared_reg_arb (N_REQ=4, WIDTH=8). Inputs change 1 ns
// after a rising edge and outputs are checked at that point too.
module tb_shared_reg_arb;
  import shared_reg_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        cg;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        valid;
  state_t      dbg_state;
  logic [1:0]  dbg_ptr;

  int checks   = 0;
  int failures = 0;

  shared_reg_arb #(.N_REQ(4), .WIDTH(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cg        (cg),
    .i_req       (req),
    .i_lock      (lock),
    .i_data      (data),
    .o_gnt       (gnt),
    .o_q         (q),
    .o_valid     (valid),
    .o_dbg_state (dbg_state),
    .o_dbg_ptr   (dbg_ptr)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_gnt,
                         input logic [7:0] e_q, input logic e_valid);
    chk({tag, "_gnt"},   32'(gnt),   32'(e_gnt));
    chk({tag, "_q"},     32'(q),     32'(e_q));
    chk({tag, "_valid"}, 32'(valid), 32'(e_valid));
  endtask

  logic [3:0] tbl_gnt [4];
  logic [7:0] tbl_q   [4];
  logic [3:0] hold_gnt;
  logic [7:0] hold_q;
  logic [1:0] hold_ptr;
  logic [3:0] resume_gnt;
  logic [7:0] resume_q;

  initial begin
    rst  = 1'b1;
    cg   = 1'b1;
    req  = 4'b0000;
    lock = 4'b0000;
    data = {8'h44, 8'hA5, 8'h22, 8'h11};
    step();
    step();
    chk_out("reset", 4'b0000, 8'h00, 1'b0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("reset_ptr", 32'(dbg_ptr), 32'd3);
    rst = 1'b0;

    // All four requesting: grant walks 0,1,2,3,0 one per cycle.
    req = 4'b1111;
    step(); chk_out("rr1", 4'b0001, 8'h00, 1'b0);
    chk("rr1_state", 32'(dbg_state), 32'(ST_GRANT));
    step(); chk_out("rr2", 4'b0010, 8'h11, 1'b1);
    step(); chk_out("rr3", 4'b0100, 8'h22, 1'b1);
    step(); chk_out("rr4", 4'b1000, 8'hA5, 1'b1);
    step(); chk_out("rr5", 4'b0001, 8'h44, 1'b1);
    chk("rr5_ptr", 32'(dbg_ptr), 32'd3);

    // Grantee 0 withdraws with nobody else asking: back to IDLE, no update.
    req = 4'b0000;
    step(); chk_out("drain", 4'b0000, 8'h44, 1'b0);
    chk("drain_state", 32'(dbg_state), 32'(ST_IDLE));

    // Sole requester 2 captured every cycle.
    req = 4'b0100;
    step(); chk_out("solo_gnt", 4'b0100, 8'h44, 1'b0);
    step(); chk_out("solo_cap1", 4'b0100, 8'hA5, 1'b1);
    chk("solo_ptr", 32'(dbg_ptr), 32'd2);
    step(); chk_out("solo_cap2", 4'b0100, 8'hA5, 1'b1);

    // Move the grant to 0, then drop req[0] before it captures.
    req = 4'b0001;
    step(); chk_out("drop_gnt0", 4'b0001, 8'hA5, 1'b0);
    req = 4'b0010;
    step(); chk_out("drop_move", 4'b0010, 8'hA5, 1'b0);
    chk("drop_ptr", 32'(dbg_ptr), 32'd2);
    req = 4'b0000;
    step(); chk_out("drop_idle", 4'b0000, 8'hA5, 1'b0);

    // Lock on requester 1 with everyone requesting; ptr is 2 here.
    req  = 4'b1111;
    lock = 4'b0010;
    step(); chk_out("lk_g3", 4'b1000, 8'hA5, 1'b0);
    step(); chk_out("lk_g0", 4'b0001, 8'h44, 1'b1);
    step(); chk_out("lk_g1", 4'b0010, 8'h11, 1'b1);
`ifdef SHARED_REG_ARB_LOCK_EN
    tbl_gnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
    tbl_q   = '{8'h22, 8'h22, 8'h22, 8'h22};
    hold_ptr   = 2'd1;
    resume_gnt = 4'b1000;
    resume_q   = 8'hA5;
`else
    tbl_gnt = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    tbl_q   = '{8'h22, 8'hA5, 8'h44, 8'h11};
    hold_ptr   = 2'd0;
    resume_gnt = 4'b0100;
    resume_q   = 8'h22;
`endif
    for (int i = 0; i < 4; i++) begin
      if (i == 3) lock = 4'b0000;
      step();
      chk_out($sformatf("lk_step%0d", i), tbl_gnt[i], tbl_q[i], 1'b1);
    end
    hold_gnt = tbl_gnt[3];
    hold_q   = tbl_q[3];

    // Clock gate closed for two edges mid-GRANT.
    cg = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out($sformatf("cg_hold%0d", i), hold_gnt, hold_q, 1'b0);
      chk($sformatf("cg_ptr%0d", i), 32'(dbg_ptr), 32'(hold_ptr));
    end
    cg = 1'b1;
    step(); chk_out("cg_resume", resume_gnt, resume_q, 1'b1);

    // Reset while a capture is pending: abort, then restart at index 0.
    rst = 1'b1;
    step(); chk_out("rst_grant", 4'b0000, 8'h00, 1'b0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_ptr", 32'(dbg_ptr), 32'd3);
    rst = 1'b0;
    step(); chk_out("rst_rearb", 4'b0001, 8'h00, 1'b0);
    step(); chk_out("rst_cap", 4'b0010, 8'h11, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
